hdmi_fifo_rd_stream: RTL and testbench

HDMI_FIFO_RD_STREAM -- requirements
Module: hdmi_fifo_rd_stream

---
 rtl/hdmi_fifo_rd_stream_if.sv | 56 +++++
 rtl/hdmi_fifo_rd_stream.sv | 150 +++++++++++++++
 tb/tb_hdmi_fifo_rd_stream.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_fifo_rd_stream_if.sv
// ---------------------------------------------------------------------------
// hdmi_fifo_rd_stream_if
// Bundles the FIFO read port and the outgoing pixel stream of
// hdmi_fifo_rd_stream.
//   master : the streaming block (drives FIFO read controls and the stream)
//   slave  : the environment (FIFO read side plus stream sink)
// Signals:
//   fifo_rd_en / fifo_rd_oce   read enable and output-register enable to FIFO
//   fifo_rd_data / fifo_rd_empty  read data and empty flag from FIFO
//   m_valid / m_ready / m_data    stream handshake and payload
//   m_sol / m_eol / pix_cnt       line framing of the head beat
//   underrun                      sticky mid-line starvation flag
// ---------------------------------------------------------------------------
interface hdmi_fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_rd_en;
    logic                  fifo_rd_oce;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_sol;
    logic                  m_eol;
    logic [15:0]           pix_cnt;
    logic                  underrun;

    modport master (
        output fifo_rd_en,
        output fifo_rd_oce,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_sol,
        output m_eol,
        output pix_cnt,
        output underrun
    );

    modport slave (
        input  fifo_rd_en,
        input  fifo_rd_oce,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_sol,
        input  m_eol,
        input  pix_cnt,
        input  underrun
    );
endinterface

// File: rtl/hdmi_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// hdmi_fifo_rd_stream
// Pulls pixels from a fixed-latency FIFO read port and presents them as a
// valid/ready stream with start/end-of-line framing. A small skid buffer of
// RD_LATENCY+2 entries absorbs the read pipeline so the stream runs at one
// beat per cycle, and credit-based issue guarantees it never overflows.
// Ports:
//   rd_clk    clock for all logic
//   rd_rst_n  asynchronous active-low reset (release sampled on rd_clk)
//   bus       hdmi_fifo_rd_stream_if.master (FIFO read port + stream)
// ---------------------------------------------------------------------------
module hdmi_fifo_rd_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LATENCY  = 1,
    parameter int LINE_PIXELS = 1280
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    hdmi_fifo_rd_stream_if.master bus
);
    localparam int D     = RD_LATENCY + 2;
    localparam int PTR_W = $clog2(D);
    localparam int CNT_W = $clog2(2 * D + 1);

    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(D);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(D - 1);
    localparam logic [15:0]      LAST_PIX = 16'(LINE_PIXELS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [D];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [RD_LATENCY-1:0] r_vld_sr;
    logic [15:0]           r_pix_cnt;
    logic                  r_underrun;

    logic [RD_LATENCY-1:0] w_vld_sr_nxt;
    logic [CNT_W-1:0]      w_in_flight;
    logic [CNT_W-1:0]      w_credit;
    logic                  w_rd_en;
    logic                  w_capture;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_first_pix;
    logic                  w_last_pix;
    logic                  w_starve;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // Reads still in the FIFO pipeline count against the buffer space
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_in_flight = w_in_flight + CNT_W'(r_vld_sr[i]);
        end
    end

    assign w_credit    = r_count + w_in_flight;
    assign w_rd_en     = rd_rst_n && !bus.fifo_rd_empty && (w_credit < DEPTH);
    assign w_capture   = r_vld_sr[RD_LATENCY-1];
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && bus.m_ready;
    assign w_first_pix = (r_pix_cnt == '0);
    assign w_last_pix  = (r_pix_cnt == LAST_PIX);
    assign w_starve    = (r_state == ST_ACTIVE) && bus.m_ready && !w_valid;

    generate
        if (RD_LATENCY == 1) begin : g_sr1
            assign w_vld_sr_nxt = w_rd_en;
        end else begin : g_srn
            assign w_vld_sr_nxt = {r_vld_sr[RD_LATENCY-2:0], w_rd_en};
        end
    endgenerate

    // Issue tracking, skid-buffer pointers and line position
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_vld_sr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pix_cnt  <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_vld_sr <= w_vld_sr_nxt;
            if (w_capture) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr  <= ptr_inc(r_rd_ptr);
                r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 16'd1;
            end
            // Capture and pop in the same cycle cancel out
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_underrun <= r_underrun | w_starve;
        end
    end

    // Data storage carries no reset; validity comes from r_count
    always_ff @(posedge rd_clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= bus.fifo_rd_data;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_pop && w_first_pix) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_pop && w_last_pix)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.fifo_rd_en  = w_rd_en;
    assign bus.fifo_rd_oce = (RD_LATENCY == 2);
    assign bus.m_valid     = w_valid;
    assign bus.m_data      = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.m_sol       = w_valid && w_first_pix;
    assign bus.m_eol       = w_valid && w_last_pix;
    assign bus.pix_cnt     = r_pix_cnt;
    // Live starvation term makes the flag visible in the starving cycle itself
    assign bus.underrun    = r_underrun | w_starve;

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        !(w_capture && (r_count == DEPTH)));

endmodule

// File: tb/tb_hdmi_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_hdmi_fifo_rd_stream
// Two instances: u0 (RD_LATENCY=1, LINE_PIXELS=4) and u1 (RD_LATENCY=2,
// LINE_PIXELS=8), each fed by a behavioural FIFO whose word k holds value k.
// ---------------------------------------------------------------------------
module tb_hdmi_fifo_rd_stream;
    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;

    always #5 clk = ~clk;

    hdmi_fifo_rd_stream_if #(.DATA_WIDTH(32)) if0 ();
    hdmi_fifo_rd_stream_if #(.DATA_WIDTH(32)) if1 ();

    hdmi_fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(1), .LINE_PIXELS(4)) u0 (
        .rd_clk   (clk),
        .rd_rst_n (rst0_n),
        .bus      (if0)
    );

    hdmi_fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(2), .LINE_PIXELS(8)) u1 (
        .rd_clk   (clk),
        .rd_rst_n (rst1_n),
        .bus      (if1)
    );

    // Behavioural FIFOs: rdN = next word index, availN = words written so far
    int          rd0 = 0;
    int          rd1 = 0;
    int          avail0 = 0;
    int          avail1 = 0;
    bit          hold0 = 1'b0;
    bit          hold1 = 1'b0;
    bit          ready0 = 1'b0;
    bit          ready1 = 1'b0;
    logic [31:0] d0 = '0;
    logic [31:0] d1a = '0;
    logic [31:0] d1b = '0;

    always @(posedge clk) begin
        if (if0.fifo_rd_en) begin
            d0  <= 32'(rd0);
            rd0 <= rd0 + 1;
        end
        if (if1.fifo_rd_en) begin
            d1a <= 32'(rd1);
            rd1 <= rd1 + 1;
        end
        d1b <= d1a;
    end

    assign if0.fifo_rd_data  = d0;
    assign if0.fifo_rd_empty = hold0 || (rd0 >= avail0);
    assign if0.m_ready       = ready0;
    assign if1.fifo_rd_data  = d1b;
    assign if1.fifo_rd_empty = hold1 || (rd1 >= avail1);
    assign if1.m_ready       = ready1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Random-phase scoreboard state
    int          exp0, exp1, rdcnt;
    bit          stall0, stall1, got;
    logic [31:0] pd0, pd1;

    task automatic sb_step(input bit drain);
        if (drain) begin
            hold0 = 1'b1; hold1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        end else begin
            ready0 = ($urandom_range(0, 3) != 0);
            hold0  = ($urandom_range(0, 3) == 0);
            ready1 = ($urandom_range(0, 2) != 0);
            hold1  = ($urandom_range(0, 2) == 0);
        end
        #1;
        if (stall0) begin
            check("rnd0_hold_valid", 32'(if0.m_valid), 32'd1);
            check("rnd0_hold_data", if0.m_data, pd0);
        end
        if (stall1) begin
            check("rnd1_hold_valid", 32'(if1.m_valid), 32'd1);
            check("rnd1_hold_data", if1.m_data, pd1);
        end
        if (if0.m_valid && ready0) begin
            check("rnd0_data", if0.m_data, 32'(exp0));
            exp0++;
        end
        if (if1.m_valid && ready1) begin
            check("rnd1_data", if1.m_data, 32'(exp1));
            exp1++;
        end
        stall0 = if0.m_valid && !ready0;
        stall1 = if1.m_valid && !ready1;
        pd0 = if0.m_data;
        pd1 = if1.m_data;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset values with a non-empty FIFO behind u0
        avail0 = 10;
        ready0 = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rd_en", 32'(if0.fifo_rd_en), 32'd0);
        check("rst_valid", 32'(if0.m_valid), 32'd0);
        check("rst_sol", 32'(if0.m_sol), 32'd0);
        check("rst_eol", 32'(if0.m_eol), 32'd0);
        check("rst_underrun", 32'(if0.underrun), 32'd0);
        check("rst_pix", 32'(if0.pix_cnt), 32'd0);
        check("rst_data", if0.m_data, 32'd0);
        check("oce_lat1", 32'(if0.fifo_rd_oce), 32'd0);
        check("oce_lat2", 32'(if1.fifo_rd_oce), 32'd1);

        // Startup and line wrap on u0: reads from cycle 0, data from cycle 2
        @(negedge clk);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        #1;
        check("start_rd_en_c0", 32'(if0.fifo_rd_en), 32'd1);
        @(negedge clk);
        #1;
        check("start_valid_c1", 32'(if0.m_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("start_valid", 32'(if0.m_valid), 32'd1);
            check("start_data", if0.m_data, 32'(i));
            check("wrap_sol", 32'(if0.m_sol), 32'((i % 4) == 0));
            check("wrap_eol", 32'(if0.m_eol), 32'((i % 4) == 3));
            check("wrap_pix", 32'(if0.pix_cnt), 32'(i % 4));
        end
        @(negedge clk);
        #1;
        check("wrap_valid_end", 32'(if0.m_valid), 32'd0);
        check("wrap_pix_end", 32'(if0.pix_cnt), 32'd2);
        check("wrap_eol_unqual", 32'(if0.m_eol), 32'd0);
        check("wrap_midline_underrun", 32'(if0.underrun), 32'd1);

        // Back-pressure on u1: exactly D=4 reads while the sink stalls
        @(negedge clk);
        avail1 = 50;
        ready1 = 1'b0;
        rdcnt  = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (if1.fifo_rd_en) rdcnt++;
            @(negedge clk);
        end
        #1;
        check("bp_read_count", 32'(rdcnt), 32'd4);
        check("bp_rd_en_idle", 32'(if1.fifo_rd_en), 32'd0);
        check("bp_valid_held", 32'(if1.m_valid), 32'd1);
        check("bp_data_held", if1.m_data, 32'd0);
        @(negedge clk);
        ready1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("bp_valid", 32'(if1.m_valid), 32'd1);
            check("bp_data", if1.m_data, 32'(i));
            @(negedge clk);
        end
        ready1 = 1'b0;

        // Reset mid-stream on u0 with its buffer full
        ready0 = 1'b0;
        avail0 = 40;
        repeat (6) @(negedge clk);
        #1;
        check("mrst_valid_pre", 32'(if0.m_valid), 32'd1);
        check("mrst_data_pre", if0.m_data, 32'd10);
        @(posedge clk);
        #2;
        rst0_n = 1'b0;
        #1;
        check("mrst_valid_async", 32'(if0.m_valid), 32'd0);
        check("mrst_pix_async", 32'(if0.pix_cnt), 32'd0);
        check("mrst_underrun_async", 32'(if0.underrun), 32'd0);
        check("mrst_rd_en_async", 32'(if0.fifo_rd_en), 32'd0);
        check("mrst_data_async", if0.m_data, 32'd0);
        @(negedge clk);
        exp0   = rd0;
        rst0_n = 1'b1;
        ready0 = 1'b1;
        got    = 1'b0;
        #1;
        check("mrst_rd_en_release", 32'(if0.fifo_rd_en), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (if0.m_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("mrst_first_beat_seen", 32'(got), 32'd1);
        check("mrst_first_sol", 32'(if0.m_sol), 32'd1);
        check("mrst_first_data", if0.m_data, 32'(exp0));

        // Underrun on u1: three words, then starvation mid-line
        @(negedge clk);
        rst1_n = 1'b0;
        ready1 = 1'b1;
        #1;
        check("ur_rst_valid", 32'(if1.m_valid), 32'd0);
        @(negedge clk);
        exp1   = rd1;
        avail1 = rd1 + 3;
        rst1_n = 1'b1;
        got    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (if1.m_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ur_first_beat_seen", 32'(got), 32'd1);
        check("ur_idle_no_flag", 32'(if1.underrun), 32'd0);
        check("ur_b0_sol", 32'(if1.m_sol), 32'd1);
        check("ur_b0_data", if1.m_data, 32'(exp1));
        @(negedge clk);
        #1;
        check("ur_b1_data", if1.m_data, 32'(exp1 + 1));
        check("ur_b1_flag", 32'(if1.underrun), 32'd0);
        @(negedge clk);
        #1;
        check("ur_b2_data", if1.m_data, 32'(exp1 + 2));
        check("ur_b2_flag", 32'(if1.underrun), 32'd0);
        @(negedge clk);
        #1;
        check("ur_starve_valid", 32'(if1.m_valid), 32'd0);
        check("ur_starve_flag", 32'(if1.underrun), 32'd1);
        check("ur_starve_pix", 32'(if1.pix_cnt), 32'd3);
        avail1 = rd1 + 5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            check("ur_sticky", 32'(if1.underrun), 32'd1);
        end

        // Random flow control on both instances after a fresh reset
        @(negedge clk);
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        @(negedge clk);
        exp0   = rd0;
        exp1   = rd1;
        avail0 = rd0 + 100000;
        avail1 = rd1 + 100000;
        stall0 = 1'b0;
        stall1 = 1'b0;
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        for (int k = 0; k < 400; k++) sb_step(1'b0);
        for (int k = 0; k < 30; k++) sb_step(1'b1);
        #1;
        check("rnd0_lossless", 32'(exp0), 32'(rd0));
        check("rnd1_lossless", 32'(exp1), 32'(rd1));
        check("rnd0_drained", 32'(if0.m_valid), 32'd0);
        check("rnd1_drained", 32'(if1.m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
